// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, reset PC, opcode field position and fetch states
// Purpose: constants and types shared by the fetch stage and its neighbours.
// Contents: ADDR_W, INSTR_W, RESET_PC, OPCODE_HI/OPCODE_LO, fetch_state_e.
package mips_pkg;

  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          OPCODE_HI = 31;
  localparam int          OPCODE_LO = 26;

  // S_REQ : PC valid, request offered when the output slot can take a word
  // S_WAIT: one request outstanding, response will be captured
  // S_DROP: one request outstanding, response belongs to a flushed path
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_out_reg.sv
// rtl/if_out_reg.sv - 1-entry valid/ready output register with flush
// Purpose: holds one fetched instruction and its address until decode takes it.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             drop the held word (wins over load and consume)
//   load              capture load_instr/load_pc and mark valid
//   load_instr/pc     word and address to capture
//   ready             consumer takes the word this cycle
//   valid/instr/pc    held word; stable while valid && !ready
module if_out_reg #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic               ready,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a consume keeps the slot full.
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem read, output slot
// Purpose: owns the PC, issues one imem read at a time, hands words to decode.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   imem_req_valid/ready/addr         read request (addr = pc)
//   imem_rsp_valid/data               in-order read response, >=1 cycle after accept
//   redirect_valid/pc                 restart fetch at redirect_pc (word aligned)
//   if_valid/ready                    handshake to decode
//   if_instr, if_opcode, if_pc,
//   if_pc_plus4                       fetched word, its opcode field, address, address+4
module fetch_unit #(
  parameter int                ADDR_W   = mips_pkg::ADDR_W,
  parameter int                INSTR_W  = mips_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [5:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4
);

  import mips_pkg::*;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              slot_free;
  logic              req_fire;
  logic              rsp_load;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Only ask for a new word when the output slot is empty or emptying now,
  // so a returning response always has somewhere to land.
  assign slot_free      = !if_valid || if_ready;
  assign imem_req_valid = !rst && (state == S_REQ) && slot_free;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A redirect in the response cycle kills that response.
  assign rsp_load = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (req_fire) begin
        req_pc <= pc;
      end

      if (redirect_valid) begin
        pc <= redirect_aligned;
      end else if (req_fire) begin
        pc <= pc + ADDR_W'(4);
      end

      case (state)
        S_REQ: begin
          // A request already handed to memory cannot be withdrawn; if it
          // goes out alongside a redirect its response must be discarded.
          if (req_fire) begin
            state <= redirect_valid ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            state <= imem_rsp_valid ? S_REQ : S_DROP;
          end else if (imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_out_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_out_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .load      (rsp_load),
    .load_instr(imem_rsp_data),
    .load_pc   (req_pc),
    .ready     (if_ready),
    .valid     (if_valid),
    .instr     (if_instr),
    .pc        (if_pc)
  );

  assign if_opcode   = if_instr[OPCODE_HI:OPCODE_LO];
  assign if_pc_plus4 = if_pc + ADDR_W'(4);

  // Memory must not answer when nothing is outstanding.
  a_no_rsp_in_req: assert property (@(posedge clk) disable iff (rst)
    !((state == S_REQ) && imem_rsp_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (lane 0 default reset PC, lane 1 near wrap)
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req_valid, req_ready, rsp_valid, redirect_valid, if_valid, if_ready;
  logic [1:0][31:0] req_addr, rsp_data, redirect_pc, if_instr, if_pc, if_pc_plus4;
  logic [1:0][5:0]  if_opcode;

  fetch_unit u_dut0 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid[0]), .imem_req_ready(req_ready[0]), .imem_req_addr(req_addr[0]),
    .imem_rsp_valid(rsp_valid[0]), .imem_rsp_data(rsp_data[0]),
    .redirect_valid(redirect_valid[0]), .redirect_pc(redirect_pc[0]),
    .if_valid(if_valid[0]), .if_ready(if_ready[0]), .if_instr(if_instr[0]),
    .if_opcode(if_opcode[0]), .if_pc(if_pc[0]), .if_pc_plus4(if_pc_plus4[0])
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid[1]), .imem_req_ready(req_ready[1]), .imem_req_addr(req_addr[1]),
    .imem_rsp_valid(rsp_valid[1]), .imem_rsp_data(rsp_data[1]),
    .redirect_valid(redirect_valid[1]), .redirect_pc(redirect_pc[1]),
    .if_valid(if_valid[1]), .if_ready(if_ready[1]), .if_instr(if_instr[1]),
    .if_opcode(if_opcode[1]), .if_pc(if_pc[1]), .if_pc_plus4(if_pc_plus4[1])
  );

  int passed = 0;
  int total  = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [31:0] req_q [2][$];
  logic [31:0] if_q  [2][$];
  int          rsp_delay [2];
  int          fire_count [2];
  int          last_fire [2];
  int          rsp_count [2];
  int          cnt [2];
  logic        pending [2];
  logic [31:0] paddr [2];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[7:2] ^ 6'h15, 2'b10, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    $display("FAIL %s: got 0x%08h, required no transfer", name, act);
  endtask

  // Monitor: samples at negedge, pops expectations on every handshake.
  initial begin
    for (int i = 0; i < 2; i++) begin
      fire_count[i] = 0; last_fire[i] = 0; rsp_count[i] = 0; pending[i] = 1'b0; cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic        g;
        logic [31:0] p, w, p4;
        g = i[0];
        if (rsp_valid[g]) rsp_count[g]++;
        if (req_valid[g] && req_ready[g]) begin
          fire_count[g]++;
          last_fire[g] = cycle;
          pending[g]   = 1'b1;
          cnt[g]       = rsp_delay[g];
          paddr[g]     = req_addr[g];
          if (req_q[g].size() == 0) unexpected("req_addr", req_addr[g]);
          else check("req_addr", req_addr[g], req_q[g].pop_front());
        end
        if (if_valid[g] && if_ready[g]) begin
          if (if_q[g].size() == 0) unexpected("if_pc", if_pc[g]);
          else begin
            p  = if_q[g].pop_front();
            w  = word(p);
            p4 = p + 32'd4;
            check("if_pc", if_pc[g], p);
            check("if_instr", if_instr[g], w);
            check("if_opcode", {26'd0, if_opcode[g]}, {26'd0, w[31:26]});
            check("if_pc_plus4", if_pc_plus4[g], p4);
          end
        end
      end
    end
  end

  // Memory responder: one-cycle response pulse rsp_delay cycles after accept.
  initial begin
    rsp_valid = '0;
    rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        logic g;
        g = i[0];
        rsp_valid[g] = 1'b0;
        if (pending[g]) begin
          cnt[g]--;
          if (cnt[g] <= 0) begin
            rsp_valid[g] = 1'b1;
            rsp_data[g]  = word(paddr[g]);
            pending[g]   = 1'b0;
          end
        end
      end
    end
  end

  task automatic fetch_n(input logic g, input int n);
    int target;
    int t;
    target = fire_count[g] + n;
    t = 0;
    req_ready[g] = 1'b1;
    while (fire_count[g] < target && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    req_ready[g] = 1'b0;
    check("fetch_count", fire_count[g], target);
  endtask

  task automatic drain(input logic g);
    int t;
    t = 0;
    while ((req_q[g].size() != 0 || if_q[g].size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_req", req_q[g].size(), 0);
    check("drain_if", if_q[g].size(), 0);
  endtask

  task automatic pulse_redirect(input logic g, input logic [31:0] pc, output int rc);
    redirect_valid[g] = 1'b1;
    redirect_pc[g]    = pc;
    rc = cycle;
    @(posedge clk);
    #1;
    redirect_valid[g] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int rel, rc, rsp0;
    rst = 1'b1;
    req_ready = '0; redirect_valid = '0; redirect_pc = '0; if_ready = 2'b11;
    rsp_delay[0] = 1; rsp_delay[1] = 1;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_req_valid", {31'd0, req_valid[0]}, 32'd0);
    check("rst_if_valid", {31'd0, if_valid[0]}, 32'd0);
    check("rst_if_pc", if_pc[0], 32'd0);
    check("rst_if_instr", if_instr[0], 32'd0);
    check("rst_addr_lane1", req_addr[1], 32'hFFFF_FFF8);

    // 1: streaming, memory always ready, k=1 -> one request every 2 cycles
    for (int i = 0; i < 8; i++) begin
      req_q[0].push_back(32'(i * 4));
      if_q[0].push_back(32'(i * 4));
    end
    rst = 1'b0;
    rel = cycle;
    fetch_n(1'b0, 8);
    check("t1_throughput", last_fire[0], rel + 14);
    drain(1'b0);

    // 2: decode stalls for 5 cycles while holding a word
    if_ready[0] = 1'b0;
    req_q[0].push_back(32'd32);
    if_q[0].push_back(32'd32);
    fetch_n(1'b0, 1);
    req_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_if_valid", {31'd0, if_valid[0]}, 32'd1);
      check("t2_if_pc", if_pc[0], 32'd32);
      check("t2_if_instr", if_instr[0], word(32'd32));
      check("t2_no_req", {31'd0, req_valid[0]}, 32'd0);
      @(posedge clk);
      #1;
    end
    req_q[0].push_back(32'd36);
    if_q[0].push_back(32'd36);
    if_ready[0] = 1'b1;
    fetch_n(1'b0, 1);
    drain(1'b0);

    // 3: redirect to unaligned 0x103 while waiting; response dropped
    rsp_delay[0] = 3;
    req_q[0].push_back(32'd40);
    fetch_n(1'b0, 1);
    pulse_redirect(1'b0, 32'h0000_0103, rc);
    req_q[0].push_back(32'h0000_0100);
    if_q[0].push_back(32'h0000_0100);
    fetch_n(1'b0, 1);
    check("t3_refetch_cycle", last_fire[0], rc + 3);
    drain(1'b0);

    // 4a: redirect in the same cycle as the response
    rsp_delay[0] = 1;
    req_q[0].push_back(32'h0000_0104);
    fetch_n(1'b0, 1);
    pulse_redirect(1'b0, 32'h0000_0200, rc);
    req_q[0].push_back(32'h0000_0200);
    if_q[0].push_back(32'h0000_0200);
    fetch_n(1'b0, 1);
    check("t4a_refetch_cycle", last_fire[0], rc + 1);
    drain(1'b0);

    // 4b: redirect in the same cycle as the request handshake
    rsp0 = rsp_count[0];
    req_q[0].push_back(32'h0000_0204);
    redirect_valid[0] = 1'b1;
    redirect_pc[0]    = 32'h0000_0300;
    req_ready[0]      = 1'b1;
    rc = cycle;
    @(posedge clk);
    #1;
    redirect_valid[0] = 1'b0;
    req_ready[0]      = 1'b0;
    check("t4b_old_req_out", last_fire[0], rc);
    req_q[0].push_back(32'h0000_0300);
    if_q[0].push_back(32'h0000_0300);
    fetch_n(1'b0, 1);
    check("t4b_refetch_cycle", last_fire[0], rc + 2);
    drain(1'b0);
    check("t4b_rsp_count", rsp_count[0] - rsp0, 2);

    // 5: wrap-around from RESET_PC = FFFF_FFF8
    req_q[1].push_back(32'hFFFF_FFF8); if_q[1].push_back(32'hFFFF_FFF8);
    req_q[1].push_back(32'hFFFF_FFFC); if_q[1].push_back(32'hFFFF_FFFC);
    req_q[1].push_back(32'h0000_0000); if_q[1].push_back(32'h0000_0000);
    fetch_n(1'b1, 3);
    drain(1'b1);

    // 6: reset while waiting; late response lands under reset
    rsp_delay[0] = 3;
    req_q[0].push_back(32'h0000_0304);
    fetch_n(1'b0, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_if_valid", {31'd0, if_valid[0]}, 32'd0);
    check("t6_if_pc", if_pc[0], 32'd0);
    check("t6_if_instr", if_instr[0], 32'd0);
    check("t6_req_valid", {31'd0, req_valid[0]}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cycle;
    rsp_delay[0] = 1;
    req_q[0].push_back(32'h0000_0000);
    if_q[0].push_back(32'h0000_0000);
    fetch_n(1'b0, 1);
    check("t6_restart_cycle", last_fire[0], rel);
    drain(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
